// File: rtl/microcode_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : microcode_sequencer_pkg
// Purpose  : Shared types and constants for the microcode sequencer: FSM
//            state encoding, microword field layout, COND encodings and the
//            default fetch control words.
// Revision : 1.0  initial release
// ============================================================================
package microcode_sequencer_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_FETCH0 = 2'd0,
    ST_FETCH1 = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Microword layout is {HALT, END, COND[1:0], CTRL}; offsets are counted
  // from the first bit above the CTRL field.
  localparam int UW_COND_OFS = 0;
  localparam int UW_END_OFS  = 2;
  localparam int UW_HALT_OFS = 3;
  localparam int UW_EXTRA_W  = 4;

  // COND field encodings
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_ZF     = 2'b01;
  localparam logic [1:0] COND_CF     = 2'b10;
  localparam logic [1:0] COND_NEVER  = 2'b11;

  // Control-line bit indices used by the fetch phase
  localparam int CB_PC_OE  = 8;
  localparam int CB_MAR_LD = 9;
  localparam int CB_MEM_RD = 10;
  localparam int CB_IR_LD  = 11;
  localparam int CB_PC_INC = 12;

  // FETCH0 puts the PC on the address path; FETCH1 reads memory into IR and
  // bumps the PC.
  localparam logic [31:0] FETCH0_DEFAULT = (32'd1 << CB_PC_OE) | (32'd1 << CB_MAR_LD);
  localparam logic [31:0] FETCH1_DEFAULT = (32'd1 << CB_MEM_RD) | (32'd1 << CB_IR_LD) |
                                           (32'd1 << CB_PC_INC);

  // Condition evaluation for one microword
  function automatic logic cond_met(input logic [1:0] cond, input logic zf, input logic cf);
    logic ok;
    ok = 1'b0;
    case (cond)
      COND_ALWAYS: ok = 1'b1;
      COND_ZF:     ok = zf;
      COND_CF:     ok = cf;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/microcode_sequencer_ram.sv
`default_nettype none
// ============================================================================
// Module   : microcode_ram
// Purpose  : Microcode store with one synchronous write port and one
//            asynchronous read port. Contents power up as all-zero and are
//            never touched by reset. A read of the address being written in
//            the same cycle returns the old word.
// Revision : 1.0  initial release
// ============================================================================
module microcode_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 20,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // Write port: one word per clock when strobed
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port
  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : microcode_sequencer
// Purpose  : Two-cycle fetch followed by up to STEPS microcoded execute
//            steps per opcode, with per-step flag conditions, END and HALT.
// Revision : 1.0  initial release
// ============================================================================
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int                CTRL_W      = 16,
  parameter int                IR_W        = 8,
  parameter int                OP_W        = 4,
  parameter int                STEPS       = 8,
  parameter logic [CTRL_W-1:0] FETCH0_WORD = CTRL_W'(FETCH0_DEFAULT),
  parameter logic [CTRL_W-1:0] FETCH1_WORD = CTRL_W'(FETCH1_DEFAULT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             zf,
  input  logic                             cf,
  input  logic [IR_W-1:0]                  ireg,
  input  logic                             uc_we,
  input  logic [OP_W+$clog2(STEPS)-1:0]    uc_addr,
  input  logic [CTRL_W+UW_EXTRA_W-1:0]     uc_wdata,
  output logic [CTRL_W-1:0]                ctrl,
  output logic [$clog2(STEPS)-1:0]         step,
  output logic                             halted
);

  localparam int                STEP_W    = $clog2(STEPS);
  localparam int                UW_W      = CTRL_W + UW_EXTRA_W;
  localparam int                AW        = OP_W + STEP_W;
  localparam int                DEPTH     = 1 << AW;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  state_e              state;
  state_e              state_nxt;
  logic [STEP_W-1:0]   step_cnt;
  logic [STEP_W-1:0]   step_nxt;
  logic [OP_W-1:0]     opcode;
  logic [UW_W-1:0]     uword;
  logic [1:0]          uw_cond;
  logic                cond_ok;
  logic                eff_halt;
  logic                eff_end;
  logic [CTRL_W-1:0]   eff_ctrl;

  assign opcode = ireg[IR_W-1 -: OP_W];

  microcode_ram #(
    .DEPTH (DEPTH),
    .WIDTH (UW_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (uc_we),
    .waddr (uc_addr),
    .wdata (uc_wdata),
    .raddr ({opcode, step_cnt}),
    .rdata (uword)
  );

  // A failed condition squashes the whole microword: CTRL, END and HALT
  assign uw_cond  = uword[CTRL_W+UW_COND_OFS +: 2];
  assign cond_ok  = cond_met(uw_cond, zf, cf);
  assign eff_halt = cond_ok & uword[CTRL_W+UW_HALT_OFS];
  assign eff_end  = cond_ok & uword[CTRL_W+UW_END_OFS];
  assign eff_ctrl = cond_ok ? uword[CTRL_W-1:0] : '0;

  // Next-state and step sequencing; en low freezes everything
  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    if (en) begin
      case (state)
        ST_FETCH0: state_nxt = ST_FETCH1;
        ST_FETCH1: begin
          state_nxt = ST_EXEC;
          step_nxt  = '0;
        end
        ST_EXEC: begin
          if (eff_halt) begin
            state_nxt = ST_HALTED;
            step_nxt  = '0;
          end else if (eff_end || (step_cnt == LAST_STEP)) begin
            state_nxt = ST_FETCH0;
            step_nxt  = '0;
          end else begin
            step_nxt  = step_cnt + STEP_ONE;
          end
        end
        ST_HALTED: begin
          state_nxt = ST_HALTED;
          step_nxt  = '0;
        end
        default: begin
          state_nxt = ST_FETCH0;
          step_nxt  = '0;
        end
      endcase
    end
  end

  // State and step registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FETCH0;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_nxt;
    end
  end

  // Control output; gated by reset and en so a frozen step never re-strobes
  always_comb begin
    ctrl = '0;
    if (rst && en) begin
      case (state)
        ST_FETCH0: ctrl = FETCH0_WORD;
        ST_FETCH1: ctrl = FETCH1_WORD;
        ST_EXEC:   ctrl = eff_ctrl;
        default:   ctrl = '0;
      endcase
    end
  end

  assign step   = step_cnt;
  assign halted = (state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_microcode_sequencer
// Purpose  : Directed self-checking bench for microcode_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_microcode_sequencer;

  localparam logic [15:0] F0W = 16'hA5A5;
  localparam logic [15:0] F1W = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        zf;
  logic        cf;
  logic [7:0]  ireg;
  logic        uc_we;
  logic [6:0]  uc_addr;
  logic [19:0] uc_wdata;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  always #5 clk = ~clk;

  microcode_sequencer #(
    .CTRL_W      (16),
    .IR_W        (8),
    .OP_W        (4),
    .STEPS       (8),
    .FETCH0_WORD (F0W),
    .FETCH1_WORD (F1W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .zf       (zf),
    .cf       (cf),
    .ireg     (ireg),
    .uc_we    (uc_we),
    .uc_addr  (uc_addr),
    .uc_wdata (uc_wdata),
    .ctrl     (ctrl),
    .step     (step),
    .halted   (halted)
  );

  typedef struct {
    string       tag;
    logic [15:0] c;
    logic [2:0]  s;
    logic        h;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [19:0] uw(input logic h, input logic e, input logic [1:0] cnd,
                                     input logic [15:0] c);
    return {h, e, cnd, c};
  endfunction

  task automatic push(input string tag, input logic [15:0] c, input logic [2:0] s,
                      input logic h);
    exp_t e;
    e.tag = tag;
    e.c   = c;
    e.s   = s;
    e.h   = h;
    sb.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    total++;
    assert (ctrl === e.c) passed++;
    else $error("FAIL %s ctrl observed=%h expected=%h", e.tag, ctrl, e.c);
    total++;
    assert (step === e.s) passed++;
    else $error("FAIL %s step observed=%0d expected=%0d", e.tag, step, e.s);
    total++;
    assert (halted === e.h) passed++;
    else $error("FAIL %s halted observed=%b expected=%b", e.tag, halted, e.h);
  endtask

  // One clock: check current outputs mid-cycle, then advance to just past the edge
  task automatic cyc(input string tag, input logic [15:0] c, input logic [2:0] s,
                     input logic h);
    push(tag, c, s, h);
    @(negedge clk);
    compare_now();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] op, input logic [2:0] st, input logic [19:0] d);
    uc_we    = 1'b1;
    uc_addr  = {op, st};
    uc_wdata = d;
    @(posedge clk);
    #1;
    uc_we    = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; zf = 1'b0; cf = 1'b0; ireg = 8'h00;
    uc_we = 1'b0; uc_addr = '0; uc_wdata = '0;
    @(posedge clk);
    #1;
    cyc("reset", 16'h0000, 3'd0, 1'b0);

    // Load microcode while held in reset
    wr(4'd3,  3'd0, uw(1'b0, 1'b0, 2'b00, 16'h0003));
    wr(4'd3,  3'd1, uw(1'b0, 1'b1, 2'b00, 16'h0000));
    wr(4'd5,  3'd0, uw(1'b0, 1'b1, 2'b01, 16'h0400));
    wr(4'd5,  3'd1, uw(1'b0, 1'b1, 2'b00, 16'h0055));
    wr(4'd6,  3'd0, uw(1'b0, 1'b0, 2'b10, 16'h2000));
    wr(4'd6,  3'd1, uw(1'b1, 1'b1, 2'b11, 16'h4000));
    wr(4'd6,  3'd2, uw(1'b0, 1'b1, 2'b00, 16'h0007));
    wr(4'd9,  3'd0, uw(1'b0, 1'b0, 2'b00, 16'h0010));
    wr(4'd9,  3'd1, uw(1'b0, 1'b0, 2'b00, 16'h0020));
    wr(4'd9,  3'd2, uw(1'b0, 1'b1, 2'b00, 16'h0040));
    wr(4'd10, 3'd0, uw(1'b0, 1'b0, 2'b00, 16'h0100));
    wr(4'd10, 3'd1, uw(1'b0, 1'b0, 2'b00, 16'h0200));
    wr(4'd10, 3'd2, uw(1'b0, 1'b0, 2'b00, 16'h0800));
    wr(4'd10, 3'd3, uw(1'b0, 1'b1, 2'b00, 16'h8000));
    wr(4'd2,  3'd0, uw(1'b1, 1'b1, 2'b00, 16'h0001));
    cyc("reset_hold", 16'h0000, 3'd0, 1'b0);

    // Op 3: plain two-step instruction
    ireg = 8'h3A;
    rst  = 1'b1;
    cyc("op3_f0", F0W, 3'd0, 1'b0);
    cyc("op3_f1", F1W, 3'd0, 1'b0);
    cyc("op3_s0", 16'h0003, 3'd0, 1'b0);
    cyc("op3_s1_end", 16'h0000, 3'd1, 1'b0);
    cyc("op3_next_f0", F0W, 3'd0, 1'b0);

    // Op 5: zf-conditional step, first failing then passing
    ireg = 8'h5C; zf = 1'b0;
    cyc("op5a_f1", F1W, 3'd0, 1'b0);
    cyc("op5_zf0_s0", 16'h0000, 3'd0, 1'b0);
    cyc("op5_zf0_s1", 16'h0055, 3'd1, 1'b0);
    cyc("op5a_next_f0", F0W, 3'd0, 1'b0);
    zf = 1'b1;
    cyc("op5b_f1", F1W, 3'd0, 1'b0);
    cyc("op5_zf1_s0", 16'h0400, 3'd0, 1'b0);
    cyc("op5b_next_f0", F0W, 3'd0, 1'b0);

    // Op 6: cf condition, then a never-step whose HALT/END must be ignored
    ireg = 8'h61; zf = 1'b0; cf = 1'b1;
    cyc("op6_f1", F1W, 3'd0, 1'b0);
    cyc("op6_cf_s0", 16'h2000, 3'd0, 1'b0);
    cyc("op6_never_s1", 16'h0000, 3'd1, 1'b0);
    cyc("op6_s2", 16'h0007, 3'd2, 1'b0);
    cyc("op6_next_f0", F0W, 3'd0, 1'b0);

    // Op 7: never written, so all-zero words run the full step range and wrap
    ireg = 8'h7F; cf = 1'b0;
    cyc("op7_f1", F1W, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) cyc("op7_step", 16'h0000, 3'(i), 1'b0);
    cyc("op7_wrap_f0", F0W, 3'd0, 1'b0);

    // Op 9: freeze in step 1 with en low
    ireg = 8'h90;
    cyc("op9_f1", F1W, 3'd0, 1'b0);
    cyc("op9_s0", 16'h0010, 3'd0, 1'b0);
    en = 1'b0;
    repeat (3) cyc("op9_frozen", 16'h0000, 3'd1, 1'b0);
    en = 1'b1;
    cyc("op9_s1_once", 16'h0020, 3'd1, 1'b0);
    cyc("op9_s2", 16'h0040, 3'd2, 1'b0);
    cyc("op9_next_f0", F0W, 3'd0, 1'b0);

    // Op 11: write the word being read; old word this cycle, new word later
    ireg = 8'hB0;
    cyc("op11_f1", F1W, 3'd0, 1'b0);
    uc_we = 1'b1; uc_addr = {4'd11, 3'd0}; uc_wdata = uw(1'b0, 1'b1, 2'b00, 16'h0ABC);
    cyc("op11_old_word", 16'h0000, 3'd0, 1'b0);
    uc_we = 1'b0;
    for (int i = 1; i < 8; i++) cyc("op11_step", 16'h0000, 3'(i), 1'b0);
    cyc("op11_wrap_f0", F0W, 3'd0, 1'b0);
    cyc("op11b_f1", F1W, 3'd0, 1'b0);
    cyc("op11_new_word", 16'h0ABC, 3'd0, 1'b0);
    cyc("op11b_next_f0", F0W, 3'd0, 1'b0);

    // Op 10: asynchronous reset in step 2, then rerun to confirm microcode kept
    ireg = 8'hA3;
    cyc("op10_f1", F1W, 3'd0, 1'b0);
    cyc("op10_s0", 16'h0100, 3'd0, 1'b0);
    cyc("op10_s1", 16'h0200, 3'd1, 1'b0);
    push("op10_s2", 16'h0800, 3'd2, 1'b0);
    #1;
    compare_now();
    rst = 1'b0;
    #1;
    push("op10_async_rst", 16'h0000, 3'd0, 1'b0);
    compare_now();
    @(posedge clk);
    #1;
    cyc("op10_rst_held", 16'h0000, 3'd0, 1'b0);
    rst = 1'b1;
    cyc("op10r_f0", F0W, 3'd0, 1'b0);
    cyc("op10r_f1", F1W, 3'd0, 1'b0);
    cyc("op10r_s0", 16'h0100, 3'd0, 1'b0);
    cyc("op10r_s1", 16'h0200, 3'd1, 1'b0);
    cyc("op10r_s2", 16'h0800, 3'd2, 1'b0);
    cyc("op10r_s3_end", 16'h8000, 3'd3, 1'b0);
    cyc("op10r_next_f0", F0W, 3'd0, 1'b0);

    // Op 2: HALT (with END also set) strobes once, then sticks until reset
    ireg = 8'h2E;
    cyc("op2_f1", F1W, 3'd0, 1'b0);
    cyc("op2_halt_step", 16'h0001, 3'd0, 1'b0);
    repeat (20) cyc("op2_halted", 16'h0000, 3'd0, 1'b1);
    rst = 1'b0;
    #1;
    push("op2_rst", 16'h0000, 3'd0, 1'b0);
    compare_now();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("op2_post_rst_f0", F0W, 3'd0, 1'b0);
    cyc("op2_post_rst_f1", F1W, 3'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 SHALL have parameter CTRL_W, default 16, meaning control-word width.
REQ-002 SHALL have parameter IR_W, default 8, meaning instruction-register width.
REQ-003 SHALL have parameter OP_W, default 4, meaning opcode width; opcode = ireg[IR_W-1 -: OP_W].
REQ-004 SHALL have parameter STEPS, default 8 (power of 2, >=2), meaning maximum execute steps per opcode; STEP_W = $clog2(STEPS).
REQ-005 SHALL have parameters FETCH0_WORD and FETCH1_WORD, CTRL_W wide, meaning the two fixed fetch control words.
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 en  input  1  advance enable; low freezes the sequencer.
REQ-009 zf  input  1  zero flag.
REQ-010 cf  input  1  carry flag.
REQ-011 ireg  input  IR_W  instruction register; stable from the FETCH1->EXEC edge until the next FETCH0.
REQ-012 uc_we  input  1  microcode write strobe.
REQ-013 uc_addr  input  OP_W+STEP_W  write address {opcode, step}.
REQ-014 uc_wdata  input  UW_W (=CTRL_W+4)  microword {HALT, END, COND[1:0], CTRL}.
REQ-015 ctrl  output  CTRL_W  control lines, combinational from state.
REQ-016 step  output  STEP_W  current execute step, 0 outside EXEC.
REQ-017 halted  output  1  high in HALTED.

Function
REQ-018 SHALL have states FETCH0, FETCH1, EXEC, HALTED; with en=1: FETCH0->FETCH1->EXEC (step 0).
REQ-019 SHALL drive ctrl = FETCH0_WORD in FETCH0 and FETCH1_WORD in FETCH1.
REQ-020 SHALL store 2^OP_W x STEPS microwords, read asynchronously at {opcode, step} in EXEC.
REQ-021 SHALL evaluate COND: 00 always, 01 zf, 10 cf, 11 never; when the condition fails, CTRL, END and HALT are all treated as 0 for that step.
REQ-022 In EXEC, SHALL drive ctrl = CTRL when the condition is met, else 0.
REQ-023 On an effective END, SHALL go EXEC->FETCH0 with step=0.
REQ-024 On an effective HALT, SHALL assert ctrl for that step, then go to HALTED; HALT overrides END.
REQ-025 Otherwise, if step=STEPS-1, SHALL wrap to FETCH0 with step=0; else step+1.
REQ-026 HALTED SHALL hold with ctrl=0 and halted=1 until rst.
REQ-027 With en=0, SHALL hold state and step and force ctrl=0, so no strobe repeats.
REQ-028 uc_we=1 SHALL write uc_wdata at uc_addr on the edge in any state, independent of en.
REQ-029 A same-cycle read of the address being written SHALL return the old word; the new word is visible the next cycle.
REQ-030 An all-zero microword SHALL be a no-op step that does not end the instruction.
REQ-031 Worst-case instruction length SHALL be 2+STEPS cycles with en held high.

Reset
REQ-032 While rst=0: state=FETCH0, step=0, halted=0, ctrl=0.
REQ-033 Reset asserted mid-instruction SHALL abort the instruction immediately; the first FETCH0 follows release.
REQ-034 Microcode storage SHALL NOT be cleared by reset; power-up contents SHALL be all-zero.

Structure
REQ-035 The shared package SHALL hold the state enum, the microword field offsets (HALT/END/COND), the COND encodings, and the FETCH word defaults built from existing control-bit indices.
REQ-036 Microcode storage SHALL be one sub-module, microcode_ram (1 sync write port, 1 async read port), parametrised by depth and width.

Verification
REQ-037 Write op 3 = {step0: CTRL 0x0003; step1: END} ; ireg=0x3X -> ctrl sequence FETCH0, FETCH1, 0x0003, 0x0000, then FETCH0.
REQ-038 Op 5 step0 {COND=01, CTRL 0x0400, END}, zf=0 -> ctrl=0, no END, step advances to 1; repeat with zf=1 -> ctrl=0x0400, then FETCH0.
REQ-039 Op 7 all-zero, STEPS=8 -> exactly 8 EXEC cycles with step 0..7 and ctrl=0, then wrap to FETCH0.
REQ-040 Op 2 step0 {HALT, CTRL 0x0001} -> ctrl=0x0001 for one cycle, then halted=1 and ctrl=0 held for 20 cycles; rst pulse -> FETCH0.
REQ-041 en=0 for 3 cycles during EXEC step 1 -> ctrl=0, step=1 frozen; on release, step1's word appears once.
REQ-042 rst asserted asynchronously mid-EXEC step 2 -> ctrl=0 within the same cycle; microcode contents unchanged after release.
